// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file.
//   - clr_state_e : clear-sweep FSM states (ST_IDLE, ST_CLEAR)
//   - DEFAULT_DATA_WIDTH / DEFAULT_ADDR_WIDTH : default geometry
//   - byte_lanes() : number of 8-bit lanes in a data word
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  function automatic int byte_lanes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file.
// Decodes the read index against the flattened register array, forces
// index 0 (when hardwired) and out-of-range indices to zero, and optionally
// forwards the word being written this cycle.
// Ports:
//   rd_idx_i    read index
//   regs_i      flattened register contents, entry i at [i*DATA_WIDTH +: DATA_WIDTH]
//   we_i        effective write enable this cycle
//   wr_idx_i    write index
//   wr_word_i   post-write value of the entry being written (already merged)
//   rd_data_o   read data
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_REGS   = 32,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic [ADDR_WIDTH-1:0]          rd_idx_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_i,
  input  logic                           we_i,
  input  logic [ADDR_WIDTH-1:0]          wr_idx_i,
  input  logic [DATA_WIDTH-1:0]          wr_word_i,
  output logic [DATA_WIDTH-1:0]          rd_data_o
);

  logic [DATA_WIDTH-1:0] stored;

  always_comb begin
    // Indices with no matching entry fall through to zero.
    stored = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(rd_idx_i) == i) begin
        stored = regs_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if ((ZERO_REG != 0) && (rd_idx_i == '0)) begin
      stored = '0;
    end

    rd_data_o = stored;
    // we_i already excludes r0 and out-of-range targets, so a match here
    // always refers to a real, writable entry.
    if ((BYPASS != 0) && we_i && (wr_idx_i == rd_idx_i)) begin
      rd_data_o = wr_word_i;
    end
  end

endmodule

// File: rtl/register_file_param.sv
// Parametrised decode-stage register file: one write port, two combinational
// read ports, optional hardwired-zero r0, optional write-to-read bypass, and a
// sequential bulk-clear sweep (one entry per clock, Busy_o while sweeping).
// Optional feature macro: REGFILE_BYTE_WRITE_EN adds Write_Byte_En_i and
// per-byte-lane write masking.
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   Reg_Write_i              write request
//   Write_Register_i         write index
//   Write_Data_i             write data
//   Write_Byte_En_i          byte lane enables (REGFILE_BYTE_WRITE_EN only)
//   Read_Register_1_i/2_i    read indices
//   Clear_i                  start bulk clear
//   Read_Data_1_o/2_o        read data
//   Busy_o                   clear sweep in progress
//   Write_Accepted_o         the write presented this cycle commits at the edge
//   dbg_state_o              clear FSM state (1 = ST_CLEAR)
//
// Write handshake: Reg_Write_i is the request and Write_Accepted_o the
// same-cycle acceptance. There is no backpressure: a request that is not
// accepted (busy, out of range, or r0) is simply dropped, so the producer
// must watch Busy_o.
module register_file_param
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_REGS   = 32,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Reg_Write_i,
  input  logic [ADDR_WIDTH-1:0] Write_Register_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
`ifdef REGFILE_BYTE_WRITE_EN
  input  logic [byte_lanes(DATA_WIDTH)-1:0] Write_Byte_En_i,
`endif
  input  logic [ADDR_WIDTH-1:0] Read_Register_1_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_2_i,
  input  logic                  Clear_i,
  output logic [DATA_WIDTH-1:0] Read_Data_1_o,
  output logic [DATA_WIDTH-1:0] Read_Data_2_o,
  output logic                  Busy_o,
  output logic                  Write_Accepted_o,
  output logic                  dbg_state_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] START_IDX = ADDR_WIDTH'((ZERO_REG != 0) ? 1 : 0);

  clr_state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]          cnt_q, cnt_d;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;

  logic                  busy;
  logic                  wr_in_range;
  logic                  we;
  logic [DATA_WIDTH-1:0] wr_word;

  assign busy        = (state_q == ST_CLEAR);
  assign wr_in_range = (int'(Write_Register_i) < NUM_REGS);
  assign we          = Reg_Write_i & ~busy & wr_in_range &
                       ~((ZERO_REG != 0) && (Write_Register_i == '0));

  assign Busy_o           = busy;
  assign Write_Accepted_o = we;
  assign dbg_state_o      = busy;

`ifdef REGFILE_BYTE_WRITE_EN
  // Post-write value: enabled lanes from Write_Data_i, the rest from the
  // current contents. This same word feeds both the register and the bypass.
  logic [DATA_WIDTH-1:0] old_word;

  always_comb begin
    old_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(Write_Register_i) == i) begin
        old_word = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    wr_word = old_word;
    for (int k = 0; k < byte_lanes(DATA_WIDTH); k++) begin
      if (Write_Byte_En_i[k]) begin
        wr_word[k*8 +: 8] = Write_Data_i[k*8 +: 8];
      end
    end
  end
`else
  assign wr_word = Write_Data_i;
`endif

  // Clear FSM next state and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (Clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = START_IDX;
        end
      end
      ST_CLEAR: begin
        // Clear_i is not looked at here: no restart mid-sweep, and a level
        // still high on the final edge is picked up one edge later in IDLE.
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Register array next state. we is forced low during the sweep, so the
  // write and the sweep never target the array in the same cycle.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (busy && (int'(cnt_q) == i)) begin
        regs_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
      if (we && (int'(Write_Register_i) == i)) begin
        regs_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_word;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .ZERO_REG  (ZERO_REG),
    .BYPASS    (BYPASS)
  ) u_rd1 (
    .rd_idx_i (Read_Register_1_i),
    .regs_i   (regs_q),
    .we_i     (we),
    .wr_idx_i (Write_Register_i),
    .wr_word_i(wr_word),
    .rd_data_o(Read_Data_1_o)
  );

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .ZERO_REG  (ZERO_REG),
    .BYPASS    (BYPASS)
  ) u_rd2 (
    .rd_idx_i (Read_Register_2_i),
    .regs_i   (regs_q),
    .we_i     (we),
    .wr_idx_i (Write_Register_i),
    .wr_word_i(wr_word),
    .rd_data_o(Read_Data_2_o)
  );

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param. Main instance uses defaults (32x32, r0
// hardwired, bypass on); a second instance (24 entries, no bypass) shares
// the stimulus to cover the no-bypass read and out-of-range indices.
module tb_register_file_param;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
`ifdef REGFILE_BYTE_WRITE_EN
  logic [3:0]  wr_be;
`endif
  logic [4:0]  rd_idx1;
  logic [4:0]  rd_idx2;
  logic        clear;

  logic [31:0] rd1, rd2, alt_rd1, alt_rd2;
  logic        busy, wacc, dbg, alt_busy, alt_wacc, alt_dbg;

  register_file_param u_dut (
    .clk              (clk),
    .reset            (reset),
    .Reg_Write_i      (reg_write),
    .Write_Register_i (wr_idx),
    .Write_Data_i     (wr_data),
`ifdef REGFILE_BYTE_WRITE_EN
    .Write_Byte_En_i  (wr_be),
`endif
    .Read_Register_1_i(rd_idx1),
    .Read_Register_2_i(rd_idx2),
    .Clear_i          (clear),
    .Read_Data_1_o    (rd1),
    .Read_Data_2_o    (rd2),
    .Busy_o           (busy),
    .Write_Accepted_o (wacc),
    .dbg_state_o      (dbg)
  );

  register_file_param #(
    .NUM_REGS(24),
    .BYPASS  (0)
  ) u_alt (
    .clk              (clk),
    .reset            (reset),
    .Reg_Write_i      (reg_write),
    .Write_Register_i (wr_idx),
    .Write_Data_i     (wr_data),
`ifdef REGFILE_BYTE_WRITE_EN
    .Write_Byte_En_i  (wr_be),
`endif
    .Read_Register_1_i(rd_idx1),
    .Read_Register_2_i(rd_idx2),
    .Clear_i          (clear),
    .Read_Data_1_o    (alt_rd1),
    .Read_Data_2_o    (alt_rd2),
    .Busy_o           (alt_busy),
    .Write_Accepted_o (alt_wacc),
    .dbg_state_o      (alt_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  localparam int S_RD1 = 0, S_RD2 = 1, S_BUSY = 2, S_WACC = 3, S_ALT_RD1 = 4, S_ALT_WACC = 5;

  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       tag_q[$];
  int          vec_count  = 0;
  int          miss_count = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_RD1:      return rd1;
      S_RD2:      return rd2;
      S_BUSY:     return {31'd0, busy};
      S_WACC:     return {31'd0, wacc};
      S_ALT_RD1:  return alt_rd1;
      S_ALT_WACC: return {31'd0, alt_wacc};
      default:    return 32'hxxxxxxxx;
    endcase
  endfunction

  // Monitor: every cycle the outputs settle before the falling edge; compare
  // everything the driver queued for this cycle.
  logic [31:0] m_exp, m_act;
  int          m_sel;
  string       m_tag;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_sel = sel_q.pop_front();
      m_tag = tag_q.pop_front();
      m_act = observe(m_sel);
      vec_count++;
      if (m_act !== m_exp) begin
        miss_count++;
        $display("FAIL %s: got %h expected %h", m_tag, m_act, m_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_out(input int sel, input logic [31:0] v, input string tag);
    sel_q.push_back(sel);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    reg_write = 1'b1;
    wr_idx    = idx;
    wr_data   = d;
`ifdef REGFILE_BYTE_WRITE_EN
    wr_be     = 4'hF;
`endif
  endtask

  task automatic nowr();
    reg_write = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_idx1 = 5'(2 * i);
      rd_idx2 = 5'(2 * i + 1);
      expect_out(S_RD1, 32'h0, tag);
      expect_out(S_RD2, 32'h0, tag);
      expect_out(S_BUSY, 32'h0, tag);
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; reg_write = 1'b0; wr_idx = '0; wr_data = '0;
    rd_idx1 = '0; rd_idx2 = '0; clear = 1'b0;
`ifdef REGFILE_BYTE_WRITE_EN
    wr_be = 4'hF;
`endif
    step();

    // Reset state
    rd_idx1 = 5'd5; rd_idx2 = 5'd31;
    expect_out(S_BUSY, 32'h0, "reset_busy");
    expect_out(S_RD1, 32'h0, "reset_rd1");
    expect_out(S_RD2, 32'h0, "reset_rd2");
    step();
    reset = 1'b1;
    step();

    // r5 write: bypass on main, old value on alt
    wr(5'd5, 32'hDEADBEEF); rd_idx1 = 5'd5; rd_idx2 = 5'd5;
    expect_out(S_WACC, 32'h1, "r5_wacc");
    expect_out(S_RD1, 32'hDEADBEEF, "r5_bypass");
    expect_out(S_ALT_RD1, 32'h0, "r5_alt_nobypass");
    step();
    nowr();
    expect_out(S_RD1, 32'hDEADBEEF, "r5_rd1");
    expect_out(S_RD2, 32'hDEADBEEF, "r5_rd2");
    expect_out(S_ALT_RD1, 32'hDEADBEEF, "r5_alt_rd1");
    step();

    // r0 is hardwired
    wr(5'd0, 32'h12345678); rd_idx1 = 5'd0;
    expect_out(S_WACC, 32'h0, "r0_wacc");
    expect_out(S_RD1, 32'h0, "r0_bypass");
    step();
    nowr();
    expect_out(S_RD1, 32'h0, "r0_rd");
    step();

    // r7 bypass vs stored value
    wr(5'd7, 32'h11111111);
    step();
    wr(5'd7, 32'hA5A5A5A5); rd_idx1 = 5'd7;
    expect_out(S_RD1, 32'hA5A5A5A5, "r7_bypass");
    expect_out(S_ALT_RD1, 32'h11111111, "r7_alt_old");
    step();
    nowr();
    expect_out(S_RD1, 32'hA5A5A5A5, "r7_rd");
    step();

    // Range boundary on the 24-entry instance
    wr(5'd23, 32'h23232323); rd_idx1 = 5'd23;
    expect_out(S_ALT_WACC, 32'h1, "alt_r23_wacc");
    expect_out(S_ALT_RD1, 32'h0, "alt_r23_old");
    step();
    wr(5'd24, 32'h24242424); rd_idx1 = 5'd24;
    expect_out(S_ALT_WACC, 32'h0, "alt_r24_wacc");
    expect_out(S_WACC, 32'h1, "main_r24_wacc");
    expect_out(S_ALT_RD1, 32'h0, "alt_r24_rd");
    step();
    nowr(); rd_idx1 = 5'd23; rd_idx2 = 5'd24;
    expect_out(S_ALT_RD1, 32'h23232323, "alt_r23_rd");
    expect_out(S_RD2, 32'h24242424, "main_r24_rd");
    step();

`ifdef REGFILE_BYTE_WRITE_EN
    // Byte-lane merge
    wr(5'd4, 32'h11223344);
    step();
    wr(5'd4, 32'hAABBCCDD); wr_be = 4'b0101; rd_idx1 = 5'd4;
    expect_out(S_RD1, 32'h11BB33DD, "be_bypass_merge");
    expect_out(S_ALT_RD1, 32'h11223344, "be_alt_old");
    step();
    wr(5'd4, 32'hFFFFFFFF); wr_be = 4'b0000;
    expect_out(S_WACC, 32'h1, "be_zero_wacc");
    expect_out(S_RD1, 32'h11BB33DD, "be_zero_bypass");
    step();
    nowr();
    expect_out(S_RD1, 32'h11BB33DD, "be_rd");
    expect_out(S_ALT_RD1, 32'h11BB33DD, "be_alt_rd");
    step();
`endif

    // Reset mid-traffic
    wr(5'd9, 32'h99999999);
    step();
    wr(5'd10, 32'hAAAAAAAA); rd_idx1 = 5'd9; reset = 1'b0;
    expect_out(S_RD1, 32'h0, "rst_mid_r9");
    expect_out(S_BUSY, 32'h0, "rst_mid_busy");
    step();
    nowr();
    read_all_zero("rst_read_all");
    reset = 1'b1;
    step();

    // Fill r1..r31, then sweep
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'hC0DE0000 | 32'(i));
      expect_out(S_WACC, 32'h1, "fill_wacc");
      step();
    end
    nowr(); clear = 1'b1;
    expect_out(S_BUSY, 32'h0, "clr_start_idle");
    step();
    for (int k = 1; k <= 31; k++) begin
      clear = (k == 31);
      rd_idx1 = 5'd1; rd_idx2 = 5'd31;
      if (k == 3) begin
        wr(5'd3, 32'h33333333);
        expect_out(S_WACC, 32'h0, "sweep_write_drop");
      end else begin
        nowr();
      end
      expect_out(S_BUSY, 32'h1, "sweep_busy");
      expect_out(S_RD1, (k >= 2) ? 32'h0 : 32'hC0DE0001, "sweep_r1");
      expect_out(S_RD2, 32'hC0DE001F, "sweep_r31");
      step();
    end
    nowr();
    // Clear_i held across the final edge: not seen there, seen one edge later.
    expect_out(S_BUSY, 32'h0, "sweep_end_idle");
    expect_out(S_RD2, 32'h0, "sweep_end_r31");
    step();
    clear = 1'b0;
    expect_out(S_BUSY, 32'h1, "held_clear_restart");
    step();
    for (int k = 0; k < 30; k++) begin
      expect_out(S_BUSY, 32'h1, "sweep2_busy");
      step();
    end
    read_all_zero("sweep2_read_all");

    // Refill, sweep, reset when counter reaches 10
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'hBEEF0000 | 32'(i));
      clear = (i == 31);
      expect_out(S_WACC, 32'h1, "refill_wacc");
      step();
    end
    nowr(); clear = 1'b0;
    for (int k = 1; k < 10; k++) begin
      rd_idx1 = 5'd1; rd_idx2 = 5'd31;
      expect_out(S_BUSY, 32'h1, "sweep3_busy");
      expect_out(S_RD1, (k >= 2) ? 32'h0 : 32'hBEEF0001, "sweep3_r1");
      expect_out(S_RD2, 32'hBEEF001F, "sweep3_r31");
      step();
    end
    rd_idx1 = 5'd10; rd_idx2 = 5'd31; reset = 1'b0;
    expect_out(S_BUSY, 32'h0, "rst_sweep_busy");
    expect_out(S_RD1, 32'h0, "rst_sweep_r10");
    expect_out(S_RD2, 32'h0, "rst_sweep_r31");
    step();
    read_all_zero("rst_sweep_read_all");
    reset = 1'b1;
    step();

    // New sweep after reset starts at index 1
    wr(5'd1, 32'h00001111);
    step();
    wr(5'd2, 32'h00002222);
    step();
    nowr(); clear = 1'b1;
    step();
    clear = 1'b0; rd_idx1 = 5'd1; rd_idx2 = 5'd2;
    expect_out(S_BUSY, 32'h1, "sweep4_busy");
    expect_out(S_RD1, 32'h00001111, "sweep4_r1_c1");
    expect_out(S_RD2, 32'h00002222, "sweep4_r2_c1");
    step();
    expect_out(S_RD1, 32'h0, "sweep4_r1_c2");
    expect_out(S_RD2, 32'h00002222, "sweep4_r2_c2");
    step();
    expect_out(S_RD2, 32'h0, "sweep4_r2_c3");
    for (int k = 3; k <= 31; k++) begin
      expect_out(S_BUSY, 32'h1, "sweep4_busy");
      step();
    end
    expect_out(S_BUSY, 32'h0, "sweep4_done");
    step();

    // Drain and report
    step();
    if (exp_q.size() != 0) begin
      miss_count++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
- Parametrised successor to the fixed 32x32 MIPS register file: configurable data width and register count, hardwired-zero register, and two combinational read ports.
- Adds an optional write-to-read bypass and a sequential bulk-clear engine (one entry per cycle, with a busy flag).
- Sits in the decode stage of the datapath; the read ports feed the ALU operand muxes and the write port is driven from writeback.

Parameters:
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5, width of the register index.
- NUM_REGS, 32, number of implemented registers; 2 <= NUM_REGS <= 2**ADDR_WIDTH.
- ZERO_REG, 1, when 1, register 0 always reads 0 and ignores writes.
- BYPASS, 1, when 1, a same-cycle write is forwarded to the read ports.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- Reg_Write_i  input  1  write request.
- Write_Register_i  input  ADDR_WIDTH  write index.
- Write_Data_i  input  DATA_WIDTH  write data.
- Write_Byte_En_i  input  DATA_WIDTH/8  byte lane enables; present only with REGFILE_BYTE_WRITE_EN.
- Read_Register_1_i  input  ADDR_WIDTH  read port 1 index.
- Read_Register_2_i  input  ADDR_WIDTH  read port 2 index.
- Clear_i  input  1  start bulk clear (single-cycle pulse or level).
- Read_Data_1_o  output  DATA_WIDTH  read port 1 data.
- Read_Data_2_o  output  DATA_WIDTH  read port 2 data.
- Busy_o  output  1  clear sweep in progress.
- Write_Accepted_o  output  1  the write this cycle will commit.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers go to 0.
  - FSM goes to IDLE and the sweep counter to 0.
  - Busy_o=0.
  - With all registers at 0, Read_Data_1_o and Read_Data_2_o read 0.
- Effective write enable, combinational:
  - we = Reg_Write_i & ~Busy_o & (Write_Register_i < NUM_REGS) & ~(ZERO_REG & Write_Register_i==0).
  - Write_Accepted_o = we.
  - The register is updated on the rising clk edge when we=1.
- Reads are combinational, with zero latency.
  - An index >= NUM_REGS returns 0.
  - Index 0 with ZERO_REG=1 returns 0.
- Bypass (BYPASS=1): if we=1 and Write_Register_i equals a read index, that port returns the post-write value.
  - Without the macro, the post-write value is Write_Data_i.
  - With the macro, it is the byte-merged value.
  - BYPASS=0: reads return the stored pre-edge value.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when Clear_i=1 at a clock edge.
  - On that edge the counter loads the start index: 1 if ZERO_REG, else 0.
  - In CLEAR, each edge zeroes reg[counter] and increments the counter.
  - CLEAR -> IDLE on the edge that clears index NUM_REGS-1.
  - Busy_o = (state==CLEAR), so it is high for exactly NUM_REGS-ZERO_REG cycles.
- Clear_i while in CLEAR is ignored; there is no restart.
  - A Clear_i still held at the CLEAR->IDLE edge is not sampled there.
  - It starts a new sweep at the next edge, sampled in IDLE.
- Clear_i and a write in the same IDLE cycle: the write commits, and the sweep later zeroes that entry.
- Writes during CLEAR are dropped with Write_Accepted_o=0; there is no stall or buffering, and the producer must honour Busy_o.
- Reads during CLEAR return current contents, so entries already swept read 0.
- Reset asserted mid-sweep: the FSM goes immediately to IDLE and all registers to 0.

Optional Feature:
- Macro: REGFILE_BYTE_WRITE_EN.
- Defined:
  - The Write_Byte_En_i port exists.
  - On a write, lane k updates only if Write_Byte_En_i[k]=1; other lanes keep their old value.
  - Bypass returns the merged word.
  - An all-zero byte enable is still a write (Write_Accepted_o=1) but changes nothing.
- Undefined: no port; every write updates the full word.

Decomposition:
- Shared package regfile_pkg holds:
  - the FSM state enum (ST_IDLE, ST_CLEAR);
  - the default DATA_WIDTH and ADDR_WIDTH constants;
  - the byte-lane count function DATA_WIDTH/8.
- One natural sub-module, regfile_read_port, instantiated twice. It covers index decode, out-of-range zeroing and the bypass/merge mux.

Test Plan:
- Reset mid-traffic, then read all indices -> every read 0, Busy_o=0.
- Write 0xDEADBEEF to r5; next cycle read r5 on both ports -> 0xDEADBEEF on both. Write 0x12345678 to r0 with ZERO_REG=1 -> Write_Accepted_o=0, r0 reads 0.
- BYPASS=1: write 0xA5A5A5A5 to r7 while reading r7 in the same cycle -> Read_Data_1_o=0xA5A5A5A5 before the edge. BYPASS=0 -> old value.
- Fill r1..r31, pulse Clear_i:
  - Busy_o high exactly 31 cycles.
  - Write attempt to r3 mid-sweep -> Write_Accepted_o=0.
  - r1 reads 0 after the first sweep cycle while r31 still holds its value.
  - All reads 0 at the end.
- Pull reset low during the sweep at counter=10 -> Busy_o=0 immediately, all registers 0, and a new Clear_i restarts from index 1.
- With REGFILE_BYTE_WRITE_EN: r4=0x11223344, then write 0xAABBCCDD with enables 4'b0101 -> r4 reads 0x11BB33DD.
